// File: rtl/edge_pkg.sv
// Shared definitions for the edge event unit: channel qualify modes and
// the helper that decides whether a filtered edge counts as an event.
package edge_pkg;

    // Per-channel qualify mode, two bits per channel on the mode bus.
    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_t;

    // True when the edge seen this cycle matches the channel's mode.
    function automatic logic qualifies(mode_t m, logic rise, logic fall);
        logic q;
        q = 1'b0;
        case (m)
            MODE_RISE: q = rise;
            MODE_FALL: q = fall;
            MODE_BOTH: q = rise | fall;
            default:   q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// Single channel: synchroniser, persistence filter, edge pulses,
// sticky qualified-event flag and saturating event counter.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   din           raw asynchronous input
//   mode          qualify mode (edge_pkg::mode_t encoding)
//   flag_clr      one-cycle strobe clearing evt_flag
//   cnt_clr       one-cycle strobe clearing evt_cnt
//   level         filtered level
//   pulse_rise    one-cycle pulse on filtered rising edge
//   pulse_fall    one-cycle pulse on filtered falling edge
//   evt_flag      sticky qualified-event flag
//   evt_cnt       saturating qualified-event count
module edge_chan
    import edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic [1:0]       mode,
    input  logic             flag_clr,
    input  logic             cnt_clr,
    output logic             level,
    output logic             pulse_rise,
    output logic             pulse_fall,
    output logic             evt_flag,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam int unsigned      FCNT_W    = $clog2(FILT_LEN + 1);
    localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FCNT_W-1:0]      filt_cnt;
    logic                   synced_c;
    logic                   toggle_c;
    logic                   rise_c;
    logic                   fall_c;
    logic                   qual_c;

    assign synced_c = sync_q[SYNC_STAGES-1];
    // The cycle that would bring the mismatch count to FILT_LEN flips the level.
    assign toggle_c = (synced_c != level) && (filt_cnt == FILT_LAST);
    assign rise_c   = toggle_c & ~level;
    assign fall_c   = toggle_c & level;
    assign qual_c   = qualifies(mode_t'(mode), rise_c, fall_c);

    // Metastability chain on the raw input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // Persistence filter; any agreement with the current level restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_cnt <= '0;
            level    <= 1'b0;
        end else if (synced_c == level) begin
            filt_cnt <= '0;
        end else if (toggle_c) begin
            filt_cnt <= '0;
            level    <= ~level;
        end else begin
            filt_cnt <= filt_cnt + FCNT_W'(1);
        end
    end

    // Edge pulses, registered alongside the level change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse_rise <= 1'b0;
            pulse_fall <= 1'b0;
        end else begin
            pulse_rise <= rise_c;
            pulse_fall <= fall_c;
        end
    end

    // Sticky flag; a new event beats a coincident clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_flag <= 1'b0;
        end else if (qual_c) begin
            evt_flag <= 1'b1;
        end else if (flag_clr) begin
            evt_flag <= 1'b0;
        end
    end

    // Saturating event counter; clear plus event lands on one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_cnt <= '0;
        end else if (cnt_clr) begin
            evt_cnt <= qual_c ? CNT_W'(1) : '0;
        end else if (qual_c && (evt_cnt != CNT_MAX)) begin
            evt_cnt <= evt_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/edge_event_unit.sv
// Multi-channel edge event unit: CH independent edge_chan instances plus
// the interrupt reduction.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   din[CH]       raw asynchronous inputs
//   mode[2*CH]    per-channel qualify mode, bits [2i+1:2i]
//   irq_en[CH]    per-channel interrupt enable
//   flag_clr[CH]  per-channel flag clear strobe
//   cnt_clr[CH]   per-channel counter clear strobe
//   level, pulse_rise, pulse_fall, evt_flag [CH]  per-channel status
//   evt_cnt[CH*CNT_W]  per-channel counts, bits [CNT_W*(i+1)-1:CNT_W*i]
//   irq           OR of evt_flag & irq_en (combinational)
module edge_event_unit
    import edge_pkg::*;
#(
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       din,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       irq_en,
    input  logic [CH-1:0]       flag_clr,
    input  logic [CH-1:0]       cnt_clr,
    output logic [CH-1:0]       level,
    output logic [CH-1:0]       pulse_rise,
    output logic [CH-1:0]       pulse_fall,
    output logic [CH-1:0]       evt_flag,
    output logic [CH*CNT_W-1:0] evt_cnt,
    output logic                irq
);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .din        (din[i]),
            .mode       (mode[2*i +: 2]),
            .flag_clr   (flag_clr[i]),
            .cnt_clr    (cnt_clr[i]),
            .level      (level[i]),
            .pulse_rise (pulse_rise[i]),
            .pulse_fall (pulse_fall[i]),
            .evt_flag   (evt_flag[i]),
            .evt_cnt    (evt_cnt[CNT_W*i +: CNT_W])
        );
    end

    // Interrupt straight from the registered flags.
    assign irq = |(evt_flag & irq_en);

endmodule
